// File: rtl/downcounter_pkg.sv
// Shared definitions for the downcounter block: state encodings and
// default width used by the counter and anything that talks to it.
`ifndef DOWNCOUNTER_PKG_SV
`define DOWNCOUNTER_PKG_SV

package downcounter_pkg;

   // State encodings; kept bit-compatible with the legacy defs.v values.
   localparam logic DC_COUNT = 1'b0;
   localparam logic DC_HALT  = 1'b1;

   // Default counter width.
   localparam int DC_WIDTH_DEFAULT = 4;

endpackage

`endif

// File: rtl/downcounter.sv
// Loadable N-bit down counter with a one-cycle terminal-count pulse.
// tc rises only on the 1 -> 0 decrement. At zero the counter either
// halts (one-shot) or reloads from the last loaded value (auto-reload).
`ifndef DOWNCOUNTER_SV
`define DOWNCOUNTER_SV

module downcounter
   import downcounter_pkg::*;
#(
   parameter int N = DC_WIDTH_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         auto_reload,
   output logic [N-1:0] q,
   output logic         tc,
   output logic         busy
);

   localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-1:0] ZERO = '0;

   logic         state;
   logic [N-1:0] reload_val;

   // Count, load, reload and halt handling with priority reset > load > en.
   always_ff @(posedge clk) begin
      if (reset) begin
         q          <= '1;
         reload_val <= '1;
         state      <= DC_COUNT;
         tc         <= 1'b0;
      end else if (load) begin
         q          <= load_val;
         reload_val <= load_val;
         tc         <= 1'b0;
         state      <= ((load_val == ZERO) && !auto_reload) ? DC_HALT : DC_COUNT;
      end else if (state == DC_HALT) begin
         q  <= ZERO;
         tc <= 1'b0;
      end else begin
         tc <= 1'b0;
         if (en) begin
            if (q > ONE) begin
               q <= q - ONE;
            end else if (q == ONE) begin
               q  <= ZERO;
               tc <= 1'b1;
            end else if (auto_reload) begin
               q <= reload_val;
            end else begin
               state <= DC_HALT;
            end
         end
      end
   end

   assign busy = (state == DC_COUNT);

endmodule

`endif

// File: doc/downcounter.md
Name: downcounter

Overview:
- Loadable N-bit down counter; the counting-direction counterpart to the team's upcounter.
- Counts toward zero and produces a one-cycle terminal-count pulse.
- Either stops at zero (one-shot) or reloads and continues (auto-reload).
- Used as the timeout/interval timer alongside upcounter-based event counting; simulated under the same defs.v flow.

Parameters:
N, 4, counter width in bits (N >= 2)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  count enable; one decrement per rising edge while high
load  input  1  load strobe; samples load_val on rising edge
load_val  input  N  value loaded into q and into the reload register
auto_reload  input  1  1 = reload on terminal count; 0 = halt at zero
q  output  N  current count value (registered)
tc  output  1  terminal-count pulse (registered)
busy  output  1  high while in COUNT state

Behaviour:
- Reset (already decided): one clock `clk`; reset `reset` is synchronous and active-high.
- Reset outcome on the next rising edge with `reset`=1:
  - q = {N{1'b1}} and reload register = {N{1'b1}}.
  - state = COUNT, tc = 0, busy = 1.
- Priority at each edge: reset > load > en.
- FSM states:
  - COUNT: decrementing allowed.
  - HALT: q frozen at 0; busy = 0.
- load = 1 (from any state):
  - q <= load_val, reload register <= load_val, tc <= 0.
  - Next state = COUNT if load_val != 0.
  - Next state = HALT if load_val == 0 and auto_reload == 0.
  - Next state = COUNT if load_val == 0 and auto_reload == 1.
  - Load latency: new value visible on q one cycle after the load edge.
- COUNT, en = 1, q > 1: q <= q - 1, tc <= 0.
- COUNT, en = 1, q == 1: q <= 0 and tc <= 1 on the same edge, so tc is high for exactly the first cycle q reads 0.
- COUNT, en = 1, q == 0:
  - auto_reload = 1: q <= reload register, tc <= 0, stay in COUNT.
  - auto_reload = 0: q holds 0, tc <= 0, next state = HALT.
- COUNT, en = 0: q holds, tc <= 0; a pending tc therefore never lasts beyond one cycle.
- HALT:
  - en ignored, q = 0, tc = 0.
  - Exit only via load or reset.
- tc asserts only on a 1 -> 0 decrement; never on load, reload, or reset.
  - Reload register = 0 in auto_reload mode: q sits at 0 with no tc pulses.
- auto_reload is sampled at the edge where q == 0 is acted on; changing it mid-count has no other effect.
- Arithmetic is unsigned, N bits; q never wraps from 0 to all-ones by decrement.
- Reset mid-count or in HALT: same result as power-up reset regardless of load/en.
- busy is combinational from state: busy = (state == COUNT).

Decomposition:
- defs.v holds the state encodings as macros: `DC_COUNT` = 1'b0, `DC_HALT` = 1'b1.
- No sub-module needed: a single always block for q/tc/state plus one busy assign.
- Guard the file with an `ifndef` include guard, matching existing blocks.

Test Plan:
1. Reset with en=1, then hold reset high 2 cycles -> q=4'hF, tc=0, busy=1; after release, q reads F,E,D... one per cycle.
2. load=1, load_val=3, auto_reload=0, then en=1 -> q=3,2,1,0; tc=1 only in the cycle q first reads 0; next cycle busy=0; q stays 0 for 10 further en cycles.
3. load_val=2, auto_reload=1, en=1 for 9 cycles -> q=2,1,0,2,1,0,2,1,0; tc high exactly 3 cycles, each coinciding with the first 0.
4. While q=5 in COUNT, assert load (load_val=9) and en together -> next q=9 (load wins), tc=0.
5. At q=1, drop en for 3 cycles, then raise it -> q holds 1; next edge q=0 with tc=1; tc drops the following cycle.
6. In HALT, load_val=0 with auto_reload=0 -> stays HALT, busy=0, tc=0; then reset -> q=F, busy=1.
